// File: rtl/nn_stage_ctrl_fifo.sv
// Input-buffer controller for one NN layer stage: stores vectors into slots and replays each one for several read passes.
// Optional STAGE_FIFO_FLUSH_EN adds a synchronous flush input that discards all stored and partial vectors.
module nn_stage_ctrl_fifo #(
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 3,
    parameter int DEPTH_W  = 3,
    parameter int PASS_W   = 2,
    parameter int TAP_W    = 4,
    parameter int PIPE_DLY = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LEN_W-1:0]         cfg_length,
    input  logic [DEPTH_W-1:0]       cfg_depth,
    input  logic [PASS_W-1:0]        cfg_passes,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic                     rd_stall,
`ifdef STAGE_FIFO_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     mem_wr_en,
    output logic [DEPTH_W+LEN_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0]        mem_wr_data,
    output logic [DEPTH_W+LEN_W-1:0] mem_rd_addr,
    output logic                     rd_en,
    output logic                     pass_done,
    output logic                     vec_done,
    output logic [TAP_W-1:0]         tap_addr,
    output logic [DEPTH_W:0]         occupancy,
    output logic                     active_pre,
    output logic                     active,
    output logic                     dbg_state
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state;
    logic [LEN_W-1:0]     wr_word;
    logic [LEN_W-1:0]     rd_word;
    logic [DEPTH_W-1:0]   wr_slot;
    logic [DEPTH_W-1:0]   rd_slot;
    logic [PASS_W-1:0]    pass_cnt;
    logic [DEPTH_W:0]     occ_next;
    logic [PIPE_DLY-1:0]  dly;
    logic                 accept;
    logic                 wr_last;
    logic                 flush_c;

`ifdef STAGE_FIFO_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Handshake: a word transfers in any cycle where in_vld and in_rdy are both high;
    // in_rdy depends only on registered occupancy (and flush), never on in_vld.
    assign in_rdy      = (occupancy <= {1'b0, cfg_depth}) & ~flush_c;
    assign accept      = in_vld & in_rdy;
    assign wr_last     = accept & (wr_word == cfg_length);
    assign mem_wr_en   = accept;
    assign mem_wr_data = in_data;
    assign mem_wr_addr = {wr_slot, wr_word};
    assign mem_rd_addr = {rd_slot, rd_word};

    assign rd_en     = (state == RUN) & ~rd_stall & ~flush_c;
    assign pass_done = rd_en & (rd_word == cfg_length);
    assign vec_done  = pass_done & (pass_cnt == cfg_passes);
    assign dbg_state = state;

    always_comb begin
        occ_next = occupancy;
        if (wr_last & ~vec_done)
            occ_next = occupancy + (DEPTH_W+1)'(1);
        else if (~wr_last & vec_done)
            occ_next = occupancy - (DEPTH_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || flush_c) begin
            state     <= IDLE;
            wr_word   <= '0;
            wr_slot   <= '0;
            rd_word   <= '0;
            rd_slot   <= '0;
            pass_cnt  <= '0;
            tap_addr  <= '0;
            occupancy <= '0;
        end else begin
            if (accept) begin
                if (wr_word == cfg_length) begin
                    wr_word <= '0;
                    wr_slot <= (wr_slot == cfg_depth) ? '0 : wr_slot + DEPTH_W'(1);
                end else begin
                    wr_word <= wr_word + LEN_W'(1);
                end
            end
            if (rd_en) begin
                tap_addr <= tap_addr + TAP_W'(1);
                if (pass_done) begin
                    rd_word <= '0;
                    if (vec_done) begin
                        pass_cnt <= '0;
                        tap_addr <= '0;
                        rd_slot  <= (rd_slot == cfg_depth) ? '0 : rd_slot + DEPTH_W'(1);
                    end else begin
                        pass_cnt <= pass_cnt + PASS_W'(1);
                    end
                end else begin
                    rd_word <= rd_word + LEN_W'(1);
                end
            end
            occupancy <= occ_next;
            // Leaving RUN only when the buffer drains keeps back-to-back vectors bubble-free.
            case (state)
                IDLE:    if (occupancy != '0) state <= RUN;
                RUN:     if (vec_done && (occ_next == '0)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Delay line tracks rd_en through the MAC pipeline; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset)
            dly <= '0;
        else
            dly <= {dly[PIPE_DLY-2:0], rd_en};
    end

    assign active     = dly[PIPE_DLY-1];
    assign active_pre = dly[PIPE_DLY-3];

endmodule
